// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/grant/response data bus between the LSU and memory
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;

  // LSU side: issues requests, receives grant and read data
  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  // Memory side: accepts requests, returns grant and read data
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit with byte-lane sizing and load extension
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [XLEN-1:0]    req_addr,
  input  logic [XLEN-1:0]    req_wdata,
  output logic               stall,
  output logic [XLEN-1:0]    rdata,
  output logic               rdata_valid,
  output logic               fault,
  load_store_unit_if.master  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] WAIT_R = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] FAULT  = 3'd4;

  logic [2:0]      state;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;

  logic            illegal;
  logic            misaligned;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;

  // Decode the incoming request: legality, alignment, byte lanes and replicated store data
  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << req_addr[1:0];
        wdata_new = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << req_addr[1:0];
        wdata_new = {2{req_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = req_wdata;
      end
    endcase
  end

  // Move the addressed byte/half to the bottom of the word and extend it by access size
  always_comb begin
    shifted = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Access sequencer: capture request in IDLE, hand it to the bus, collect load data
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (illegal || misaligned) begin
              state <= FAULT;
            end else begin
              we_q     <= req_we;
              funct3_q <= req_funct3;
              addr_q   <= req_addr;
              be_q     <= be_new;
              wdata_q  <= wdata_new;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.bus_gnt) state <= we_q ? DONE : WAIT_R;
        end
        WAIT_R: begin
          if (bus.bus_rvalid) begin
            rdata <= load_ext;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus fields come only from registered request state, so they hold steady through REQ
  always_comb begin
    bus.bus_req   = (state == REQ);
    bus.bus_we    = (state == REQ) && we_q;
    bus.bus_addr  = (state == REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    bus.bus_be    = (state == REQ) ? be_q : 4'b0000;
    bus.bus_wdata = ((state == REQ) && we_q) ? wdata_q : '0;
  end

  // Core-facing status: hold the pipeline until the access resolves
  always_comb begin
    stall       = req_valid && (state != DONE) && (state != FAULT);
    rdata_valid = (state == DONE) && !we_q;
    fault       = (state == FAULT);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  load_store_unit_if #(.XLEN(32)) bus_if ();

  load_store_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .fault       (fault),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    step();
    step();
    n_reset = 1'b1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %0b exp 0", bus_if.bus_req); end
    checks++; if (bus_if.bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we got %0b exp 0", bus_if.bus_we); end
    checks++; if (bus_if.bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got %h exp 0", bus_if.bus_addr); end
    checks++; if (bus_if.bus_be !== 4'h0) begin errors++; $display("FAIL reset_bus_be got %b exp 0000", bus_if.bus_be); end
    checks++; if (bus_if.bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata got %h exp 0", bus_if.bus_wdata); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid got %0b exp 0", rdata_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b exp 0", fault); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lo got %0b exp 0", stall); end
    req_valid = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hi got %0b exp 1", stall); end
    req_valid = 1'b0;
    #1;
  endtask

  task automatic test_sb();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h0000_0102; req_wdata = 32'h0000_00A5;
    bus_if.bus_gnt = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_c0 got %0b exp 1", stall); end
    step();
    checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL sb_req got %0b exp 1", bus_if.bus_req); end
    checks++; if (bus_if.bus_we !== 1'b1) begin errors++; $display("FAIL sb_we got %0b exp 1", bus_if.bus_we); end
    checks++; if (bus_if.bus_addr !== 32'h0000_0100) begin errors++; $display("FAIL sb_addr got %h exp 00000100", bus_if.bus_addr); end
    checks++; if (bus_if.bus_be !== 4'b0100) begin errors++; $display("FAIL sb_be got %b exp 0100", bus_if.bus_be); end
    checks++; if (bus_if.bus_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", bus_if.bus_wdata); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_c1 got %0b exp 1", stall); end
    step();
    bus_if.bus_gnt = 1'b0;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall_c2 got %0b exp 0", stall); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL sb_req_done got %0b exp 0", bus_if.bus_req); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL sb_no_rvalid got %0b exp 0", rdata_valid); end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_sh();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h0000_0106; req_wdata = 32'h1234_BEEF;
    step();
    bus_if.bus_gnt = 1'b1;
    checks++; if (bus_if.bus_addr !== 32'h0000_0104) begin errors++; $display("FAIL sh_addr got %h exp 00000104", bus_if.bus_addr); end
    checks++; if (bus_if.bus_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", bus_if.bus_be); end
    checks++; if (bus_if.bus_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", bus_if.bus_wdata); end
    step();
    bus_if.bus_gnt = 1'b0;
    req_valid = 1'b0;
    step();
  endtask

  task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] word, input logic [31:0] exp, input logic [31:0] prev);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3;
    req_addr = addr; req_wdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s_stall_c0 got %0b exp 1", name, stall); end
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL %s_req_wait%0d got %0b exp 1", name, i, bus_if.bus_req); end
      checks++; if (bus_if.bus_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr_wait%0d got %h exp %h", name, i, bus_if.bus_addr, {addr[31:2], 2'b00}); end
      checks++; if (bus_if.bus_wdata !== 32'h0) begin errors++; $display("FAIL %s_wdata_wait%0d got %h exp 0", name, i, bus_if.bus_wdata); end
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = 32'hDEAD_BEEF;
      step();
    end
    bus_if.bus_gnt = 1'b1;
    checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL %s_req_gnt got %0b exp 1", name, bus_if.bus_req); end
    step();
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL %s_req_waitr got %0b exp 0", name, bus_if.bus_req); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %0b exp 0", name, rdata_valid); end
    checks++; if (rdata !== prev) begin errors++; $display("FAIL %s_rdata_hold got %h exp %h", name, rdata, prev); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s_stall_waitr got %0b exp 1", name, stall); end
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = word;
    step();
    bus_if.bus_rvalid = 1'b0;
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL %s_rdata_valid got %0b exp 1", name, rdata_valid); end
    checks++; if (rdata !== exp) begin errors++; $display("FAIL %s_rdata got %h exp %h", name, rdata, exp); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_stall_done got %0b exp 0", name, stall); end
    req_valid = 1'b0;
    step();
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_pulse got %0b exp 0", name, rdata_valid); end
    checks++; if (rdata !== exp) begin errors++; $display("FAIL %s_rdata_after got %h exp %h", name, rdata, exp); end
  endtask

  task automatic test_lb_lbu();
    run_load("lb",  3'b000, 32'h0000_0203, 32'h80FF_1234, 32'hFFFF_FF80, 32'h0000_0000);
    run_load("lbu", 3'b100, 32'h0000_0203, 32'h80FF_1234, 32'h0000_0080, 32'hFFFF_FF80);
  endtask

  task automatic test_lh_lhu();
    run_load("lh",  3'b001, 32'h0000_0202, 32'h9ABC_0000, 32'hFFFF_9ABC, 32'h0000_0080);
    run_load("lhu", 3'b101, 32'h0000_0202, 32'h9ABC_0000, 32'h0000_9ABC, 32'hFFFF_9ABC);
  endtask

  task automatic test_faults();
    logic        we_tab [0:3];
    logic [2:0]  f3_tab [0:3];
    logic [31:0] ad_tab [0:3];
    we_tab[0] = 1'b0; f3_tab[0] = 3'b010; ad_tab[0] = 32'h0000_0201;
    we_tab[1] = 1'b1; f3_tab[1] = 3'b100; ad_tab[1] = 32'h0000_0300;
    we_tab[2] = 1'b0; f3_tab[2] = 3'b001; ad_tab[2] = 32'h0000_0105;
    we_tab[3] = 1'b0; f3_tab[3] = 3'b011; ad_tab[3] = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = we_tab[i]; req_funct3 = f3_tab[i];
      req_addr = ad_tab[i]; req_wdata = 32'h5555_5555;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fault%0d_stall_c0 got %0b exp 1", i, stall); end
      checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL fault%0d_req_c0 got %0b exp 0", i, bus_if.bus_req); end
      step();
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault%0d_pulse got %0b exp 1", i, fault); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fault%0d_stall_c1 got %0b exp 0", i, stall); end
      checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL fault%0d_req_c1 got %0b exp 0", i, bus_if.bus_req); end
      checks++; if (rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL fault%0d_rdata got %h exp 00009abc", i, rdata); end
      req_valid = 1'b0;
      step();
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault%0d_clear got %0b exp 0", i, fault); end
      checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL fault%0d_req_c2 got %0b exp 0", i, bus_if.bus_req); end
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0400; req_wdata = 32'h0;
    step();
    bus_if.bus_gnt = 1'b1;
    step();
    bus_if.bus_gnt = 1'b0;
    req_valid = 1'b0;
    n_reset = 1'b0;
    step();
    n_reset = 1'b1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %0b exp 0", bus_if.bus_req); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata_clr got %h exp 0", rdata); end
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hDEAD_BEEF;
    step();
    bus_if.bus_rvalid = 1'b0;
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid got %0b exp 0", rdata_valid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", rdata); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_req_late got %0b exp 0", bus_if.bus_req); end
    req_valid = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_idle_stall got %0b exp 1", stall); end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_0300; req_wdata = 32'h1122_3344;
    bus_if.bus_gnt = 1'b1;
    step();
    checks++; if (bus_if.bus_be !== 4'b1111) begin errors++; $display("FAIL b2b_sw_be got %b exp 1111", bus_if.bus_be); end
    if (bus_if.bus_req && bus_if.bus_we) begin
      for (int b = 0; b < 4; b++)
        if (bus_if.bus_be[b]) mem[bus_if.bus_addr[9:2]][8*b +: 8] = bus_if.bus_wdata[8*b +: 8];
    end
    step();
    bus_if.bus_gnt = 1'b0;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_sw_done got %0b exp 0", stall); end
    req_valid = 1'b0;
    step();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0300; req_wdata = 32'h0;
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL b2b_bubble_req got %0b exp 0", bus_if.bus_req); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_bubble_stall got %0b exp 1", stall); end
    step();
    checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL b2b_lw_req got %0b exp 1", bus_if.bus_req); end
    checks++; if (bus_if.bus_we !== 1'b0) begin errors++; $display("FAIL b2b_lw_we got %0b exp 0", bus_if.bus_we); end
    checks++; if (bus_if.bus_wdata !== 32'h0) begin errors++; $display("FAIL b2b_lw_wdata got %h exp 0", bus_if.bus_wdata); end
    bus_if.bus_gnt = 1'b1;
    step();
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = mem[10'h300 >> 2];
    step();
    bus_if.bus_rvalid = 1'b0;
    checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL b2b_lw_valid got %0b exp 1", rdata_valid); end
    checks++; if (rdata !== 32'h1122_3344) begin errors++; $display("FAIL b2b_lw_rdata got %h exp 11223344", rdata); end
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    n_reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
    test_reset();
    test_sb();
    test_sh();
    test_lb_lbu();
    test_lh_lhu();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core's execute stage (ALU-computed address, rs2 store data) and a request/grant/response data bus. It replaces the core's combinational data-memory port. It sizes and aligns store data into byte lanes, extracts and extends load data, flags misaligned or illegal accesses, and holds the core with `stall` until each access completes.

## Interface
- `XLEN`, 32, data and address width; only 32 is supported.

- `clk`  in  1  rising-edge clock
- `n_reset`  in  1  synchronous, active-low reset
- `req_valid`  in  1  core requests a memory access this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32 size/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  XLEN  byte address (ALU output)
- `req_wdata`  in  XLEN  store data (rs2), LSBs significant
- `stall`  out  1  core must hold the PC and all `req_*` inputs
- `rdata`  out  XLEN  extended load result
- `rdata_valid`  out  1  one-cycle pulse: `rdata` is the new load result
- `fault`  out  1  one-cycle pulse: access rejected (misaligned or illegal funct3)
- `bus_req`  out  1  bus request
- `bus_we`  out  1  bus write
- `bus_addr`  out  XLEN  word address: `req_addr` with [1:0] forced to 00
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  XLEN  lane-replicated store data
- `bus_gnt`  in  1  bus accepts the request this cycle
- `bus_rvalid`  in  1  read data valid
- `bus_rdata`  in  XLEN  read data word

## Operation
- States: IDLE, REQ, WAIT_R, DONE, FAULT.
- IDLE, `req_valid`=0: stay in IDLE.
- IDLE, `req_valid`=1, access legal: register `req_*`, go to REQ.
- IDLE, `req_valid`=1, access misaligned or illegal: go to FAULT. No bus access is made.
- REQ: drive `bus_req`=1 with registered fields. On `bus_gnt`, a store goes to DONE and a load goes to WAIT_R.
- WAIT_R: on `bus_rvalid`, capture and extract `bus_rdata`, then go to DONE.
- DONE: `stall`=0. `rdata_valid`=1 for loads only. Return to IDLE.
- FAULT: `stall`=0, `fault`=1. Return to IDLE.
- `stall` = `req_valid` & state is not DONE & state is not FAULT. This is combinational.
- Misaligned access: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠00.
- Illegal access: funct3 of 011, 110 or 111. Stores with funct3 100 or 101 are also illegal.
- Byte enables: B gives 0001<<`addr[1:0]`. H gives 0011<<`addr[1:0]`. W gives 1111.
- Store data: B sends `{4{wdata[7:0]}}`. H sends `{2{wdata[15:0]}}`. W sends `wdata` unchanged.
- Load data: shift `bus_rdata` right by 8·`addr[1:0]`. Sign-extend for B/H; zero-extend for BU/HU.
- `rdata` holds the last load result until the next load completes. Stores and faults do not change it.
- Bus fields are stable while `bus_req`=1.
- `bus_wdata`=0 during loads. All bus outputs are 0 when not in REQ.

## Timing
- Reset (`n_reset`=0 at a rising edge) forces state IDLE. After that edge, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `rdata`, `rdata_valid` and `fault` are all 0. `stall` then equals `req_valid` (combinational).
- Reset mid-access aborts the access. `bus_req` drops after the reset edge. A late `bus_rvalid` is ignored.
- Minimum latency with request at cycle 0:
  - Store with same-cycle grant: REQ at cycle 1, DONE at cycle 2. `stall` is high in cycles 0–1.
  - Load with grant at cycle 1 and `bus_rvalid` at cycle 2: DONE at cycle 3, `rdata_valid` at cycle 3.
- Fault: FAULT at cycle 1. `stall` is high in cycle 0 only.
- There is one IDLE bubble between back-to-back accesses. The core presents the next request in the cycle after DONE.
- Ignored inputs: `bus_gnt` outside REQ; `bus_rvalid` outside WAIT_R; `bus_rvalid` in the same cycle as `bus_gnt` (read data must arrive at least 1 cycle after the grant).
- Wait states: the block remains in REQ or WAIT_R indefinitely. There is no timeout.
- `req_*` is sampled only in IDLE. Changes in later states are ignored.

## Test plan
- **SB**: `addr`=0x102, `wdata`=0xA5, immediate grant → `bus_addr`=0x100, `bus_be`=0100, `bus_wdata`=0xA5A5A5A5. `stall` high for 2 cycles.
- **LB / LBU**: `addr`=0x203, `bus_rdata`=0x80FF_1234, grant after 3 wait cycles, rvalid one cycle later → LB gives `rdata`=0xFFFFFF80 with a single `rdata_valid` pulse. LBU at the same address gives 0x00000080.
- **LH / LHU**: `addr`=0x202, `bus_rdata`=0x9ABC_0000 → LH gives 0xFFFF9ABC and LHU gives 0x00009ABC.
- **Faults**: LW at 0x201 → `fault` pulse at cycle 1, `bus_req` never asserted, `stall` high 1 cycle. Store with funct3 100 → same response.
- **Reset mid-access**: load in WAIT_R, assert `n_reset`=0 for one cycle, then `bus_rvalid`=1 with 0xDEADBEEF → no `rdata_valid`, `rdata`=0, state IDLE.
- **Back-to-back**: SW 0x11223344 to 0x300, then LW from 0x300 with a memory model → `rdata`=0x11223344. Exactly one IDLE cycle between the two DONE/REQ sequences.
